// File: rtl/div_iter_param_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and default operand width.
package div_iter_param_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_iter_param_step.sv
// One combinational non-restoring division step on a {rem, quo} shift register.
module div_iter_param_step
  import div_iter_param_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] dvs_ext;

  // The top bit of rem is dropped on the shift; the true partial remainder
  // always fits WIDTH+1 signed bits, so the modular add/sub lands correctly.
  always_comb begin
    rem_sh  = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    dvs_ext = {1'b0, divisor_i};
    rem_o   = rem_i[WIDTH] ? (rem_sh + dvs_ext) : (rem_sh - dvs_ext);
    quo_o   = {quo_i[WIDTH-2:0], ~rem_o[WIDTH]};
  end

endmodule

// File: rtl/div_iter_param.sv
// Iterative signed/unsigned divider: WIDTH+2 cycle latency, one-cycle fast path for exceptions.
module div_iter_param
  import div_iter_param_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic             ready,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             exception_q, exception_d;

  logic             a_neg, b_neg, div_zero, sgn_ovf;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   step_rem, rem_adj;
  logic [WIDTH-1:0] step_quo, quo_fix, rem_fix;

  div_iter_param_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Operand conditioning; |MIN| wraps to MIN, which reads correctly as unsigned.
  always_comb begin
    a_neg    = is_signed & A[WIDTH-1];
    b_neg    = is_signed & B[WIDTH-1];
    abs_a    = a_neg ? (~A + 1'b1) : A;
    abs_b    = b_neg ? (~B + 1'b1) : B;
    div_zero = (B == '0);
    sgn_ovf  = is_signed & (A == MIN_VAL) & (B == '1);
    rem_adj  = rem_q[WIDTH] ? (rem_q + {1'b0, dvs_q}) : rem_q;
    quo_fix  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix  = neg_rem_q ? (~rem_adj[WIDTH-1:0] + 1'b1) : rem_adj[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    exception_d = exception_q;
    // A start strobe in any state aborts whatever is in flight.
    if (ctrl_DIV) begin
      if (div_zero || sgn_ovf) begin
        state_d     = ST_DONE;
        result_d    = div_zero ? '1 : MIN_VAL;
        remainder_d = div_zero ? A : '0;
        exception_d = 1'b1;
      end else begin
        state_d   = ST_RUN;
        cnt_d     = '0;
        rem_d     = '0;
        quo_d     = abs_a;
        dvs_d     = abs_b;
        neg_quo_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d     = ST_DONE;
          result_d    = quo_fix;
          remainder_d = rem_fix;
          exception_d = 1'b0;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      exception_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      exception_q <= exception_d;
    end
  end

  assign result    = result_q;
  assign remainder = remainder_q;
  assign exception = exception_q;
  assign ready     = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_FIX);

endmodule

// File: tb/tb_div_iter_param.sv
// Directed bench for div_iter_param with a reference model feeding an expected-result queue.
module tb_div_iter_param;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clock = 1'b0;
  logic         reset, ctrl_DIV, is_signed;
  logic [W-1:0] A, B;
  logic [W-1:0] result, remainder;
  logic         exception, ready, busy;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         exc;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_e;
  int   errors = 0;
  int   checks = 0;

  div_iter_param #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV), .is_signed(is_signed),
    .A(A), .B(B), .result(result), .remainder(remainder),
    .exception(exception), .ready(ready), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit is_fast(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    return (b == '0) || (s && a == MINV && b == '1);
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      e.res = '1; e.rem = a; e.exc = 1'b1;
    end else if (s && a == MINV && b == '1) begin
      e.res = MINV; e.rem = '0; e.exc = 1'b1;
    end else if (s) begin
      e.res = sa / sb; e.rem = sa % sb; e.exc = 1'b0;
    end else begin
      e.res = a / b; e.rem = a % b; e.exc = 1'b0;
    end
    return e;
  endfunction

  // Called in cycle T (just after a rising edge); returns in cycle T+1.
  task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    A = a; B = b; is_signed = s; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_ready(input int exp_lat, input bit fast);
    int   n = 1;
    bit   seen = 0;
    exp_t e;
    while (n <= W + 10 && !seen) begin
      @(negedge clock);
      chk("busy_during_op", {31'b0, busy}, {31'b0, (!fast && n <= W + 1)});
      if (ready) seen = 1;
      else begin
        @(posedge clock); #1;
        n++;
      end
    end
    chk("ready_latency", n, exp_lat);
    if (seen) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("remainder", remainder, e.rem);
        chk("exception", {31'b0, exception}, {31'b0, e.exc});
        last_e = e;
      end
      @(posedge clock); #1;
      @(negedge clock);
      chk("ready_one_cycle", {31'b0, ready}, 32'd0);
      chk("result_held", result, last_e.res);
    end
    @(posedge clock); #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bit f;
    f = is_fast(a, b, s);
    sb_q.push_back(model(a, b, s));
    pulse(a, b, s);
    wait_ready(f ? 1 : W + 2, f);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ready_cnt;
    reset = 1'b1; ctrl_DIV = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    last_e = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_result", result, '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_exception", {31'b0, exception}, 32'd0);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clock); #1;

    do_op(32'd100, 32'd7, 1'b0);
    do_op(32'hFFFF_FF9C, 32'd7, 1'b1);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(32'h0000_1234, 32'd0, 1'b0);
    do_op(32'h0000_1234, 32'd0, 1'b1);
    do_op(MINV, 32'hFFFF_FFFF, 1'b1);
    do_op(MINV, 32'hFFFF_FFFF, 1'b0);
    do_op(32'd100, 32'hFFFF_FFF9, 1'b1);
    do_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
    do_op(32'd5, 32'd9, 1'b0);

    // Restart at T+10: only the second operation may complete.
    pulse(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      chk("abort_no_ready", {31'b0, ready}, 32'd0);
      chk("abort_result_held", result, last_e.res);
      chk("abort_rem_held", remainder, last_e.rem);
      @(posedge clock); #1;
    end
    sb_q.push_back(model(32'd9, 32'd3, 1'b0));
    pulse(32'd9, 32'd3, 1'b0);
    wait_ready(W + 2, 1'b0);

    // Reset in the middle of a run.
    pulse(32'd100, 32'd7, 1'b0);
    repeat (4) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_result", result, '0);
    chk("midrst_remainder", remainder, '0);
    chk("midrst_exception", {31'b0, exception}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    ready_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (ready) ready_cnt++;
    end
    chk("midrst_no_ready", ready_cnt, 32'd0);
    @(posedge clock); #1;
    do_op(32'd50, 32'd5, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom_range(1, 1000);
      if (i % 2 == 1) rb = $urandom;
      do_op(ra, rb, logic'(i % 3 != 0));
    end

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
